// File: rtl/vx_ti_pkg.sv
// Shared types for the ray-trace dispatch path between the SFU and the T&I unit.
package vx_ti_pkg;

   // Packed ray: eight 32-bit words, origin in the low bits, root BVH index on top.
   localparam int unsigned TI_RAY_BITS   = 256;
   localparam int unsigned TI_ORIGIN_OFF = 0;
   localparam int unsigned TI_DIR_OFF    = 96;
   localparam int unsigned TI_TMAX_OFF   = 192;
   localparam int unsigned TI_ROOT_OFF   = 224;

   // Member order is MSB first, so org_x lands at TI_ORIGIN_OFF and root at TI_ROOT_OFF.
   typedef struct packed {
      logic [31:0] root;
      logic [31:0] tmax;
      logic [31:0] dir_z;
      logic [31:0] dir_y;
      logic [31:0] dir_x;
      logic [31:0] org_z;
      logic [31:0] org_y;
      logic [31:0] org_x;
   } ti_ray_t;

   // Per-lane hit record returned by the T&I unit.
   typedef struct packed {
      logic        hit;
      logic [31:0] t;
      logic [31:0] tri_idx;
   } ti_hit_t;

   typedef enum logic [1:0] {
      TI_IDLE   = 2'd0,
      TI_ISSUE  = 2'd1,
      TI_WAIT   = 2'd2,
      TI_COMMIT = 2'd3
   } ti_disp_state_e;

endpackage

// File: rtl/vx_ti_lane_sel.sv
// Lowest-set-bit finder over a lane mask; gives the lane index and an any-set flag.
module vx_ti_lane_sel #(
   parameter  int unsigned NUM_LANES = 4,
   localparam int unsigned LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
   input  logic [NUM_LANES-1:0] mask_i,
   output logic [LANE_W-1:0]    idx_o,
   output logic                 valid_o
);

   // Scan from the top lane down so the lowest set lane is the last one written.
   always_comb begin
      // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
      idx_o   = '0;
      valid_o = 1'b0;
      for (int i = NUM_LANES - 1; i >= 0; i--) begin
         if (mask_i[i]) begin
            idx_o   = LANE_W'(i);
            valid_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/vx_ti_ray_dispatch.sv
// Serializes a warp-wide ray-trace request to the single-ray T&I unit, lowest
// active lane first, and gathers the per-lane hit records into one commit.
module vx_ti_ray_dispatch
   import vx_ti_pkg::*;
#(
   parameter  int unsigned NUM_LANES = 4,
   parameter  int unsigned TAG_WIDTH = 16,
   parameter  int unsigned RAY_BITS  = TI_RAY_BITS,
   localparam int unsigned LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
   input  logic                          clk,
   input  logic                          reset,
   // warp request from the SFU
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic [NUM_LANES-1:0]          req_tmask,
   input  logic [NUM_LANES*RAY_BITS-1:0] req_rays,
   input  logic [TAG_WIDTH-1:0]          req_tag,
   // single ray to the T&I unit
   output logic                          trav_req_valid,
   input  logic                          trav_req_ready,
   output logic [RAY_BITS-1:0]           trav_req_ray,
   output logic [LANE_W-1:0]             trav_req_lane,
   // hit record from the T&I unit
   input  logic                          trav_rsp_valid,
   output logic                          trav_rsp_ready,
   input  logic                          trav_rsp_hit,
   input  logic [31:0]                   trav_rsp_t,
   input  logic [31:0]                   trav_rsp_tri,
   // warp result to commit
   output logic                          commit_valid,
   input  logic                          commit_ready,
   output logic [NUM_LANES-1:0]          commit_tmask,
   output logic [TAG_WIDTH-1:0]          commit_tag,
   output logic [NUM_LANES-1:0]          commit_hit,
   output logic [NUM_LANES*32-1:0]       commit_t,
   output logic [NUM_LANES*32-1:0]       commit_tri,
   output logic                          busy
);

   ti_disp_state_e        state_q;
   logic [NUM_LANES-1:0]  tmask_q;
   logic [NUM_LANES-1:0]  pending_q;
   logic [TAG_WIDTH-1:0]  tag_q;
   logic [LANE_W-1:0]     cur_lane_q;
   logic [RAY_BITS-1:0]   rays_q [NUM_LANES];
   ti_hit_t               hits_q [NUM_LANES];

   logic [LANE_W-1:0]     sel_idx;
   logic                  sel_valid;

   vx_ti_lane_sel #(
      .NUM_LANES (NUM_LANES)
   ) u_lane_sel (
      .mask_i  (pending_q),
      .idx_o   (sel_idx),
      .valid_o (sel_valid)
   );

   // Dispatch FSM together with the captured request and the result slots.
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: ray and result storage is reset too, so every data output reads zero after reset.
         state_q    <= TI_IDLE;
         tmask_q    <= '0;
         pending_q  <= '0;
         tag_q      <= '0;
         cur_lane_q <= '0;
         for (int i = 0; i < NUM_LANES; i++) begin
            rays_q[i] <= '0;
            hits_q[i] <= '0;
         end
      end else begin
         // NOTE: non-blocking throughout, so every branch sees this cycle's register values.
         case (state_q)
            TI_IDLE: begin
               if (req_valid) begin
                  tmask_q   <= req_tmask;
                  pending_q <= req_tmask;
                  tag_q     <= req_tag;
                  for (int i = 0; i < NUM_LANES; i++) begin
                     rays_q[i] <= req_rays[i*RAY_BITS +: RAY_BITS];
                     hits_q[i] <= '0;
                  end
                  state_q <= (req_tmask != '0) ? TI_ISSUE : TI_COMMIT;
               end
            end
            TI_ISSUE: begin
               if (trav_req_ready) begin
                  cur_lane_q         <= sel_idx;
                  pending_q[sel_idx] <= 1'b0;
                  state_q            <= TI_WAIT;
               end
            end
            TI_WAIT: begin
               if (trav_rsp_valid) begin
                  hits_q[cur_lane_q] <= '{hit: trav_rsp_hit, t: trav_rsp_t, tri_idx: trav_rsp_tri};
                  // pending_q already has the outstanding lane cleared
                  state_q <= sel_valid ? TI_ISSUE : TI_COMMIT;
               end
            end
            TI_COMMIT: begin
               if (commit_ready) begin
                  state_q <= TI_IDLE;
               end
            end
            default: state_q <= TI_IDLE;
         endcase
      end
   end

   // Handshake outputs decode the state register only.
   assign req_ready      = (state_q == TI_IDLE);
   assign trav_req_valid = (state_q == TI_ISSUE);
   assign trav_rsp_ready = (state_q == TI_WAIT);
   assign commit_valid   = (state_q == TI_COMMIT);
   assign busy           = (state_q != TI_IDLE);

   // pending_q is frozen while ISSUE stalls, so the selected ray holds steady.
   assign trav_req_ray  = rays_q[sel_idx];
   assign trav_req_lane = sel_idx;

   assign commit_tmask = tmask_q;
   assign commit_tag   = tag_q;

   // Flatten the per-lane result slots onto the commit buses.
   always_comb begin
      commit_hit = '0;
      commit_t   = '0;
      commit_tri = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         commit_hit[i]         = hits_q[i].hit;
         commit_t[i*32 +: 32]   = hits_q[i].t;
         commit_tri[i*32 +: 32] = hits_q[i].tri_idx;
      end
   end

endmodule
